iter_alu: RTL and testbench
===========================

Name: iter_alu

Overview:
- Parametrised, registered successor to the datapath's combinational ALU.
- Keeps the existing op encoding and adds SRA, SLTU, and iterative signed/unsigned multiply and divide with HI/LO results.
- Sits in the EX stage behind a valid/ready handshake; the pipeline stalls on `in_ready` low during multi-cycle ops.

Parameters:
- `WIDTH`, 32: operand and result width; must be ≥ 4.
- `SHAMT_W`, `$clog2(WIDTH)`: width of the shift-amount port.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept a request this cycle.
- `alu_ctrl`  in  4  opcode.
- `data1`  in  `WIDTH`  operand A.
- `data2`  in  `WIDTH`  operand B.
- `shamt`  in  `SHAMT_W`  shift amount.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `res_lo`  out  `WIDTH`  main result / product low / quotient.
- `res_hi`  out  `WIDTH`  product high / remainder; 0 for single-cycle ops.
- `zero`  out  1  `res_lo == 0`.
- `busy`  out  1  multiply/divide iteration in progress.

Behaviour:
- Reset (async, any state): state = IDLE; `out_valid`, `busy`, `res_lo`, `res_hi` = 0. `zero` is 1, because it is derived from `res_lo == 0`. Iteration counter is cleared. A reset mid-iteration aborts the op with no output.
- Opcodes:
  - 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR.
  - 0110 LUI: `{data2[15:0], 0}`, zero-filled to `WIDTH`.
  - 0111 SLT (signed), 1011 SLTU (unsigned).
  - 1000 SLL: `data1 << shamt`. 1001 SRL: logical right shift. 1010 SRA: arithmetic right shift. Shift results are truncated to `WIDTH`.
  - 1100 MULT, 1101 MULTU.
  - 1110 DIV, 1111 DIVU.
  - 0000: result 0.
- Add/sub wrap modulo 2^`WIDTH`; no overflow flag.
- `in_ready = (state == IDLE) || (state == DONE && out_ready)`. A request is accepted on a rising edge where `in_valid && in_ready`; operands and opcode are captured at that edge.
- States:
  - IDLE → DONE: accepted single-cycle op. Result is registered at the accept edge, so latency is 1 cycle.
  - IDLE → ITER: accepted MULT/MULTU/DIV/DIVU with nonzero divisor. Signed ops store operand magnitudes and result signs.
  - ITER: one shift-add (mul) or restoring shift-subtract (div) step per cycle, `WIDTH` cycles, then → FIX. `busy` = 1 in ITER and FIX.
  - FIX: applies sign correction, loads `res_lo`/`res_hi`, then → DONE. Multi-cycle latency from the accept edge to `out_valid` is `WIDTH + 2` edges.
  - DONE: `out_valid` = 1. Outputs are held stable until `out_ready`. On `out_ready`, go to IDLE, or accept a new request in the same cycle (back-to-back, throughput 1 per cycle for single-cycle ops).
- Multiply: the full 2·`WIDTH`-bit product goes to `{res_hi, res_lo}`.
- Divide:
  - Quotient is truncated toward zero; the remainder has the sign of the dividend.
  - Divisor = 0: no iteration; go directly to DONE with latency 1. `res_lo` = all ones; `res_hi` = `data1`.
  - DIV of (most-negative value) / −1: `res_lo` = most-negative value, `res_hi` = 0.
- `in_valid` is ignored while busy or while DONE is stalled. Operand changes while busy have no effect.

Test Plan (`WIDTH`=32):
- ADD 0x7FFFFFFF + 1, `out_ready`=1: `out_valid` one cycle after accept, `res_lo`=0x80000000, `zero`=0. SUB 5−5 gives `res_lo`=0 and `zero`=1. Back-to-back ADDs give one result per cycle.
- SRA 0x80000000, `shamt`=4 → 0xF8000000. SRL → 0x08000000. SLT(−1,1)=1. SLTU(0xFFFFFFFF,1)=0. LUI with `data2`=0x1234 → 0x12340000.
- MULT −3 × 5: `busy` for 33 cycles. `out_valid` at 34 edges after accept with `res_hi`=0xFFFFFFFF, `res_lo`=0xFFFFFFF1. MULTU 0xFFFFFFFF² → `res_hi`=0xFFFFFFFE, `res_lo`=0x00000001.
- DIV −7/2 → `res_lo`=0xFFFFFFFD, `res_hi`=0xFFFFFFFF. DIVU 7/0 → latency 1, `res_lo`=0xFFFFFFFF, `res_hi`=7. DIV 0x80000000 / −1 → `res_lo`=0x80000000, `res_hi`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE. Outputs must be stable, `in_ready`=0, and a pulsed `in_valid` is not accepted. On release, a new request is accepted in the same cycle.
- Assert `rst` asynchronously mid-ITER at cycle 10 of a MULT. Outputs clear immediately, with `zero`=1. After release, `in_ready`=1 and a fresh ADD completes correctly.

Source files
------------

// File: rtl/iter_alu.sv
// iter_alu: registered EX-stage ALU with iterative multiply/divide.
// Single-cycle ops finish one edge after accept; MULT/MULTU/DIV/DIVU
// iterate WIDTH steps, then a sign-fix cycle, then present HI/LO.
// Ports:
//   clk, rst           clock, async active-high reset
//   in_valid/in_ready  request handshake (opcode + operands captured)
//   alu_ctrl           4-bit opcode
//   data1, data2       operands A/B; shamt shift amount
//   out_valid/out_ready result handshake
//   res_lo, res_hi     result / product lo,hi / quotient,remainder
//   zero               res_lo == 0
//   busy               multiply/divide iteration in progress
module iter_alu #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         alu_ctrl,
   input  logic [WIDTH-1:0]   data1,
   input  logic [WIDTH-1:0]   data2,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   res_lo,
   output logic [WIDTH-1:0]   res_hi,
   output logic               zero,
   output logic               busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_SUB   = 4'b0010;
   localparam logic [3:0] OP_AND   = 4'b0011;
   localparam logic [3:0] OP_OR    = 4'b0100;
   localparam logic [3:0] OP_XOR   = 4'b0101;
   localparam logic [3:0] OP_LUI   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_SLL   = 4'b1000;
   localparam logic [3:0] OP_SRL   = 4'b1001;
   localparam logic [3:0] OP_SRA   = 4'b1010;
   localparam logic [3:0] OP_SLTU  = 4'b1011;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ITER,
      S_FIX,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic             is_div_q, is_div_d;
   logic             neg_lo_q, neg_lo_d;
   logic             neg_hi_q, neg_hi_d;
   logic [WIDTH-1:0] res_lo_q, res_lo_d;
   logic [WIDTH-1:0] res_hi_q, res_hi_d;

   logic             accept;
   logic             is_md;
   logic             is_div;
   logic             sgn_op;
   logic             div_zero;
   logic             start_iter;
   logic             s1, s2;
   logic [WIDTH-1:0] mag1, mag2;
   logic [WIDTH-1:0] alu_lo, alu_hi;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shl;
   logic [WIDTH:0]   div_diff;
   logic [2*WIDTH-1:0] prod, prod_fix;

   // Request decode (valid only at an accepting edge)
   assign accept     = in_valid && in_ready;
   assign is_md      = (alu_ctrl[3:2] == 2'b11);
   assign is_div     = is_md && alu_ctrl[1];
   // MULT/DIV have bit0 clear; MULTU/DIVU set
   assign sgn_op     = is_md && !alu_ctrl[0];
   assign div_zero   = is_div && (data2 == '0);
   assign start_iter = accept && is_md && !div_zero;

   assign s1   = sgn_op && data1[WIDTH-1];
   assign s2   = sgn_op && data2[WIDTH-1];
   assign mag1 = s1 ? ('0 - data1) : data1;
   assign mag2 = s2 ? ('0 - data2) : data2;

   // Single-cycle results, including the divide-by-zero shortcut
   always_comb begin
      alu_lo = '0;
      alu_hi = '0;
      case (alu_ctrl)
         OP_ADD:  alu_lo = data1 + data2;
         OP_SUB:  alu_lo = data1 - data2;
         OP_AND:  alu_lo = data1 & data2;
         OP_OR:   alu_lo = data1 | data2;
         OP_XOR:  alu_lo = data1 ^ data2;
         OP_LUI:  alu_lo = data2 << 16;
         OP_SLT:  alu_lo[0] = $signed(data1) < $signed(data2);
         OP_SLTU: alu_lo[0] = data1 < data2;
         OP_SLL:  alu_lo = data1 << shamt;
         OP_SRL:  alu_lo = data1 >> shamt;
         OP_SRA:  alu_lo = $signed(data1) >>> shamt;
         default: begin
            if (div_zero) begin
               alu_lo = '1;
               alu_hi = data1;
            end
         end
      endcase
   end

   // One iteration step.
   // Multiply: {hi,lo} holds partial product and remaining multiplier.
   // Divide: {hi,lo} holds partial remainder and quotient bits.
   assign mul_sum  = {1'b0, acc_hi_q}
                   + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
   assign div_shl  = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign div_diff = div_shl - {1'b0, opnd_q};

   assign prod     = {acc_hi_q, acc_lo_q};
   assign prod_fix = neg_lo_q ? ('0 - prod) : prod;

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) state_d = start_iter ? S_ITER : S_DONE;
         end
         S_ITER: begin
            if (cnt_q == LAST) state_d = S_FIX;
         end
         S_FIX: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            if (accept) state_d = start_iter ? S_ITER : S_DONE;
            else if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      in_ready  = (state_q == S_IDLE) ||
                  ((state_q == S_DONE) && out_ready);
      out_valid = (state_q == S_DONE);
      busy      = (state_q == S_ITER) || (state_q == S_FIX);
   end

   // Datapath next-state
   always_comb begin
      cnt_d    = cnt_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      opnd_d   = opnd_q;
      is_div_d = is_div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      if (accept) begin
         if (start_iter) begin
            cnt_d    = '0;
            acc_hi_d = '0;
            acc_lo_d = mag1;
            opnd_d   = mag2;
            is_div_d = is_div;
            neg_lo_d = s1 ^ s2;
            neg_hi_d = s1;
         end else begin
            res_lo_d = alu_lo;
            res_hi_d = alu_hi;
         end
      end else if (state_q == S_ITER) begin
         cnt_d = cnt_q + 1'b1;
         if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
               acc_hi_d = div_diff[WIDTH-1:0];
            end else begin
               acc_hi_d = div_shl[WIDTH-1:0];
            end
            acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
         end else begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
         end
      end else if (state_q == S_FIX) begin
         if (is_div_q) begin
            res_lo_d = neg_lo_q ? ('0 - acc_lo_q) : acc_lo_q;
            res_hi_d = neg_hi_q ? ('0 - acc_hi_q) : acc_hi_q;
         end else begin
            res_lo_d = prod_fix[WIDTH-1:0];
            res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         res_lo_q <= '0;
         res_hi_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opnd_q   <= opnd_d;
         is_div_q <= is_div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
      end
   end

   assign res_lo = res_lo_q;
   assign res_hi = res_hi_q;
   assign zero   = (res_lo_q == '0);

endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed vectors for iter_alu (WIDTH=32).
// Hand-computed results, latency, backpressure and mid-op reset.
module tb_iter_alu;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_ctrl;
   logic [31:0] data1;
   logic [31:0] data2;
   logic [4:0]  shamt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] res_lo;
   logic [31:0] res_hi;
   logic        zero;
   logic        busy;

   int n_vec;
   int n_err;

   iter_alu #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctrl  (alu_ctrl),
      .data1     (data1),
      .data2     (data2),
      .shamt     (shamt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res_lo    (res_lo),
      .res_hi    (res_hi),
      .zero      (zero),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one request, wait for out_valid, check everything
   task automatic run_op(input string tag,
                         input logic [3:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [4:0] sh,
                         input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi,
                         input int exp_lat,
                         input int exp_busy);
      int lat;
      int bcnt;
      @(negedge clk);
      chk({tag, ".rdy"}, in_ready, 1);
      alu_ctrl = op;
      data1    = a;
      data2    = b;
      shamt    = sh;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      data1 = 32'hDEAD_BEEF;
      data2 = 32'h0BAD_F00D;
      lat  = 1;
      bcnt = 0;
      @(negedge clk);
      while (!out_valid && lat < 100) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      chk({tag, ".lat"}, lat, exp_lat);
      chk({tag, ".busy"}, bcnt, exp_busy);
      chk({tag, ".lo"}, res_lo, exp_lo);
      chk({tag, ".hi"}, res_hi, exp_hi);
      chk({tag, ".zero"}, zero, (exp_lo == 32'h0));
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      alu_ctrl  = 4'h0;
      data1     = '0;
      data2     = '0;
      shamt     = '0;

      @(negedge clk);
      chk("rst.ov", out_valid, 0);
      chk("rst.busy", busy, 0);
      chk("rst.lo", res_lo, 0);
      chk("rst.hi", res_hi, 0);
      chk("rst.zero", zero, 1);
      chk("rst.rdy", in_ready, 1);
      rst = 1'b0;

      // Single-cycle ops
      run_op("add", 4'b0001, 32'h7FFF_FFFF, 32'h1, 0,
             32'h8000_0000, 0, 1, 0);
      run_op("sub", 4'b0010, 32'd5, 32'd5, 0, 32'h0, 0, 1, 0);
      run_op("and", 4'b0011, 32'hF0F0_1234, 32'h0FF0_FF00, 0,
             32'h00F0_1200, 0, 1, 0);
      run_op("or", 4'b0100, 32'hF000_0001, 32'h0000_0F00, 0,
             32'hF000_0F01, 0, 1, 0);
      run_op("xor", 4'b0101, 32'hFFFF_0000, 32'hFF00_FF00, 0,
             32'h00FF_FF00, 0, 1, 0);
      run_op("lui", 4'b0110, 32'h0, 32'h0000_1234, 0,
             32'h1234_0000, 0, 1, 0);
      run_op("slt", 4'b0111, 32'hFFFF_FFFF, 32'h1, 0,
             32'h1, 0, 1, 0);
      run_op("sltu", 4'b1011, 32'hFFFF_FFFF, 32'h1, 0,
             32'h0, 0, 1, 0);
      run_op("sll", 4'b1000, 32'h0000_0003, 32'h0, 5'd31,
             32'h8000_0000, 0, 1, 0);
      run_op("srl", 4'b1001, 32'h8000_0000, 32'h0, 5'd4,
             32'h0800_0000, 0, 1, 0);
      run_op("sra", 4'b1010, 32'h8000_0000, 32'h0, 5'd4,
             32'hF800_0000, 0, 1, 0);
      run_op("nop", 4'b0000, 32'h1234_5678, 32'h1, 0,
             32'h0, 0, 1, 0);

      // Multi-cycle ops
      run_op("mult", 4'b1100, 32'hFFFF_FFFD, 32'd5, 0,
             32'hFFFF_FFF1, 32'hFFFF_FFFF, 34, 33);
      run_op("multu", 4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,
             32'h0000_0001, 32'hFFFF_FFFE, 34, 33);
      run_op("div", 4'b1110, 32'hFFFF_FFF9, 32'd2, 0,
             32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 33);
      run_op("div2", 4'b1110, 32'd7, 32'hFFFF_FFFE, 0,
             32'hFFFF_FFFD, 32'h1, 34, 33);
      run_op("divu", 4'b1111, 32'd100, 32'd7, 0,
             32'd14, 32'd2, 34, 33);
      run_op("divu0", 4'b1111, 32'd7, 32'd0, 0,
             32'hFFFF_FFFF, 32'd7, 1, 0);
      run_op("divmin", 4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 0,
             32'h8000_0000, 32'h0, 34, 33);

      // Back-to-back single-cycle ops
      @(negedge clk);
      alu_ctrl = 4'b0001;
      data1    = 32'd1;
      data2    = 32'd2;
      in_valid = 1'b1;
      @(negedge clk);
      chk("b2b.ov1", out_valid, 1);
      chk("b2b.lo1", res_lo, 32'd3);
      chk("b2b.rdy", in_ready, 1);
      data1 = 32'd10;
      data2 = 32'd20;
      @(negedge clk);
      chk("b2b.ov2", out_valid, 1);
      chk("b2b.lo2", res_lo, 32'd30);
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b.idle", out_valid, 0);

      // Backpressure in DONE
      out_ready = 1'b0;
      alu_ctrl  = 4'b0001;
      data1     = 32'd2;
      data2     = 32'd3;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bp.ov", out_valid, 1);
         chk("bp.lo", res_lo, 32'd5);
         chk("bp.rdy", in_ready, 0);
         if (i == 1) begin
            alu_ctrl = 4'b0010;
            data1    = 32'd9;
            data2    = 32'd1;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      chk("bp.hold", res_lo, 32'd5);
      out_ready = 1'b1;
      alu_ctrl  = 4'b0001;
      data1     = 32'd100;
      data2     = 32'd1;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp.ov2", out_valid, 1);
      chk("bp.lo2", res_lo, 32'd101);

      // Async reset in the middle of a MULT
      @(negedge clk);
      alu_ctrl = 4'b1100;
      data1    = 32'd1000;
      data2    = 32'd1000;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 chk("mr.busy0", busy, 1);
      #1 rst = 1'b1;
      #1;
      chk("mr.ov", out_valid, 0);
      chk("mr.busy", busy, 0);
      chk("mr.lo", res_lo, 0);
      chk("mr.hi", res_hi, 0);
      chk("mr.zero", zero, 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mr.rdy", in_ready, 1);
      chk("mr.ov2", out_valid, 0);
      run_op("mr.add", 4'b0001, 32'd4, 32'd5, 0, 32'd9, 0, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
